// File: rtl/odd_multiple_lut_loader_pkg.sv
// Shared constants, FSM state type and word-width helper for the
// run-time programmable odd-multiple LUT loader.
package odd_multiple_lut_loader_pkg;

  localparam int LUT_DEPTH = 9;
  localparam int IDX_2A    = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_ODD,
    LOAD_2A
  } state_t;

  function automatic int lut_w(input int w);
    return w + 4;
  endfunction

endpackage

// File: rtl/odd_multiple_lut_loader_lut_regfile.sv
// Nine-word LUT storage: one write port, synchronous clear, and a registered
// one-hot read where the 2A select bit overrides all others.
module lut_regfile
  import odd_multiple_lut_loader_pkg::*;
#(
  parameter int W = 6,
  localparam int LW = lut_w(W)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [3:0]           widx,
  input  logic [LW-1:0]        wdata,
  input  logic [LUT_DEPTH-1:0] rd_sel,
  input  logic                 rd_en,
  output logic [LW-1:0]        rd_data
);

  logic [LW-1:0] mem [LUT_DEPTH];
  logic [LW-1:0] sel_word;

  // Descending scan so the lowest set bit wins among entries 0..7.
  always_comb begin
    sel_word = '0;
    if (rd_sel[IDX_2A]) begin
      sel_word = mem[IDX_2A];
    end else begin
      for (int i = IDX_2A - 1; i >= 0; i--) begin
        if (rd_sel[i]) sel_word = mem[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LUT_DEPTH; i++) mem[i] <= '0;
      rd_data <= '0;
    end else begin
      if (we && (widx < 4'(LUT_DEPTH))) mem[widx] <= wdata;
      rd_data <= rd_en ? sel_word : '0;
    end
  end

endmodule

// File: rtl/odd_multiple_lut_loader.sv
// Coefficient loader: accepts A, writes A,3A,..,15A then 2A into the LUT over
// nine cycles, and serves gated one-hot reads of the finished table.
module odd_multiple_lut_loader
  import odd_multiple_lut_loader_pkg::*;
#(
  parameter int W = 6,
  localparam int LW = lut_w(W)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 coef_valid,
  output logic                 coef_ready,
  input  logic [W-1:0]         coef,
  input  logic [LUT_DEPTH-1:0] rd_sel,
  output logic [LW-1:0]        rd_data,
  output logic                 lut_valid,
  output logic                 busy,
  output logic                 load_done
);

  state_t        state, state_nxt;
  logic [W-1:0]  a_q;
  logic [LW-1:0] acc;
  logic [LW-1:0] two_a;
  logic [2:0]    idx;
  logic          we;
  logic [3:0]    widx;
  logic [LW-1:0] wdata;
  logic          accept;

  assign two_a      = {{(LW-W-1){1'b0}}, a_q, 1'b0};
  assign coef_ready = ~busy;
  assign accept     = coef_valid && coef_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    we        = 1'b0;
    widx      = {1'b0, idx};
    wdata     = acc;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (coef_valid) state_nxt = LOAD_ODD;
      end
      LOAD_ODD: begin
        we = 1'b1;
        if (idx == 3'd7) state_nxt = LOAD_2A;
      end
      LOAD_2A: begin
        we        = 1'b1;
        widx      = 4'(IDX_2A);
        wdata     = two_a;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulator steps by 2A so each odd multiple costs a single add.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q       <= '0;
      acc       <= '0;
      idx       <= '0;
      lut_valid <= 1'b0;
      load_done <= 1'b0;
    end else begin
      load_done <= (state == LOAD_2A);
      if (accept) begin
        a_q       <= coef;
        acc       <= {4'b0000, coef};
        idx       <= '0;
        lut_valid <= 1'b0;
      end else if (state == LOAD_ODD) begin
        acc <= acc + two_a;
        idx <= idx + 3'd1;
      end else if (state == LOAD_2A) begin
        lut_valid <= 1'b1;
      end
    end
  end

  lut_regfile #(.W(W)) u_lut (
    .clk     (clk),
    .reset   (reset),
    .we      (we),
    .widx    (widx),
    .wdata   (wdata),
    .rd_sel  (rd_sel),
    .rd_en   (lut_valid),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_odd_multiple_lut_loader.sv
// Bench for odd_multiple_lut_loader: cycle-level behavioural model compared
// every cycle, directed scenarios with literal values, then random traffic.
module tb_odd_multiple_lut_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       coef_valid = 1'b0;
  logic       coef_ready;
  logic [5:0] coef = '0;
  logic [8:0] rd_sel = '0;
  logic [9:0] rd_data;
  logic       lut_valid;
  logic       busy;
  logic       load_done;

  int n_checks = 0;
  int n_fail = 0;

  odd_multiple_lut_loader #(.W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .coef       (coef),
    .rd_sel     (rd_sel),
    .rd_data    (rd_data),
    .lut_valid  (lut_valid),
    .busy       (busy),
    .load_done  (load_done)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase counts cycles since acceptance (0 = idle).
  int m_entry [9];
  int m_phase = 0;
  int m_a = 0;
  bit m_valid = 0;
  int exp_rd = 0;
  bit exp_done = 0;
  bit live = 0;

  function automatic int pick(input logic [8:0] sel);
    if (sel[8]) return m_entry[8];
    for (int i = 0; i < 8; i++) if (sel[i]) return m_entry[i];
    return 0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 9; i++) m_entry[i] = 0;
      m_phase = 0; m_a = 0; m_valid = 0; exp_rd = 0; exp_done = 0;
      live = 1;
    end else begin
      exp_rd = m_valid ? pick(rd_sel) : 0;
      exp_done = 0;
      if (m_phase == 0) begin
        if (coef_valid) begin
          m_a = int'(coef); m_phase = 1; m_valid = 0;
        end
      end else if (m_phase <= 8) begin
        m_entry[m_phase-1] = (2 * (m_phase - 1) + 1) * m_a;
        m_phase++;
      end else begin
        m_entry[8] = 2 * m_a;
        m_valid = 1; exp_done = 1; m_phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      check("rd_data", 32'(rd_data), 32'(exp_rd));
      check("lut_valid", 32'(lut_valid), 32'(m_valid));
      check("busy", 32'(busy), 32'(m_phase != 0));
      check("coef_ready", 32'(coef_ready), 32'(m_phase == 0));
      check("load_done", 32'(load_done), 32'(exp_done));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input int extra);
    int k;
    coef = 6'(a);
    coef_valid = 1'b1;
    k = 0;
    while (!coef_ready && k < 20) begin
      tick();
      k++;
    end
    check("accept_wait", 32'(k < 20), 32'd1);
    tick();
    coef_valid = 1'b0;
    repeat (extra) tick();
  endtask

  task automatic read_check(input logic [8:0] sel, input int exp, input string name);
    rd_sel = sel;
    tick();
    check(name, 32'(rd_data), 32'(exp));
  endtask

  int exp32 [9] = '{32, 96, 160, 224, 288, 352, 416, 480, 64};
  int cnt;
  logic [8:0] one;

  initial begin
    tick();
    tick();
    check("rst_lut_valid", 32'(lut_valid), 32'd0);
    check("rst_ready", 32'(coef_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick();

    // coef=32 basic load
    load(32, 9);
    check("c32_valid", 32'(lut_valid), 32'd1);
    check("c32_done", 32'(load_done), 32'd1);
    for (int i = 0; i < 9; i++) begin
      one = 9'd1 << i;
      read_check(one, exp32[i], "c32_entry");
    end
    check("c32_done_drop", 32'(load_done), 32'd0);
    read_check(9'b000000100, 160, "c32_sel2");

    // coef=63 boundary
    load(63, 9);
    read_check(9'b010000000, 945, "c63_entry7");
    read_check(9'b100000001, 126, "c63_2a_prio");

    // coef_valid held with a second coefficient during a load
    coef = 6'd32;
    coef_valid = 1'b1;
    tick();
    coef = 6'd5;
    cnt = 0;
    for (int i = 0; i < 9; i++) begin
      if (!coef_ready) cnt++;
      if (i < 8) tick();
    end
    check("hold_ready_low_cycles", 32'(cnt), 32'd9);
    tick();
    check("hold_ready_back", 32'(coef_ready), 32'd1);
    check("hold_valid32", 32'(lut_valid), 32'd1);
    rd_sel = 9'b000000100;
    tick();
    check("hold_old_read", 32'(rd_data), 32'd160);
    check("hold_busy5", 32'(busy), 32'd1);
    coef_valid = 1'b0;
    repeat (9) tick();
    read_check(9'b000000100, 25, "hold_c5_entry2");

    // reset in the middle of a load
    coef = 6'd32;
    coef_valid = 1'b1;
    tick();
    coef_valid = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_valid", 32'(lut_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(coef_ready), 32'd1);
    for (int i = 0; i < 9; i++) begin
      one = 9'd1 << i;
      read_check(one, 0, "midrst_read");
    end
    load(7, 9);
    read_check(9'b010000000, 105, "c7_entry7");

    // coef=0 and rd_sel=0
    load(0, 9);
    check("c0_valid", 32'(lut_valid), 32'd1);
    read_check(9'b000010000, 0, "c0_entry4");
    read_check(9'b100000000, 0, "c0_entry8");
    read_check(9'b000000000, 0, "c0_sel0");

    // reload over a valid table
    load(32, 9);
    coef = 6'd10;
    coef_valid = 1'b1;
    rd_sel = 9'b000001000;
    tick();
    coef_valid = 1'b0;
    check("reload_old_read", 32'(rd_data), 32'd224);
    check("reload_valid_drop", 32'(lut_valid), 32'd0);
    repeat (3) tick();
    check("reload_read_zero", 32'(rd_data), 32'd0);
    repeat (6) tick();
    read_check(9'b000001000, 70, "reload_entry3");

    // randomized traffic, checked by the per-cycle model
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      coef_valid = ($urandom_range(0, 2) == 0);
      coef = 6'($urandom_range(0, 63));
      case ($urandom_range(0, 3))
        0: rd_sel = '0;
        1: rd_sel = 9'd1 << $urandom_range(0, 8);
        2: rd_sel = 9'($urandom);
        default: rd_sel = 9'b100000001;
      endcase
      tick();
    end
    reset = 1'b0;
    coef_valid = 1'b0;
    repeat (12) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/odd_multiple_lut_loader.md
# odd_multiple_lut_loader

Writer side of the memory-based constant multiplier. Accepts a new coefficient A over a valid/ready handshake and sequentially computes and writes the nine LUT words the multiplier reads: A, 3A, 5A, …, 15A, then 2A. Once loaded, it serves one-hot word-select reads in the same format the 4-to-9 decoder produces. It replaces the hard-wired constant table, so the coefficient can be reprogrammed at run time.

## Interface
- W, 6, coefficient width; LUT word width is W+4.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- coef_valid  in  1  coefficient offered.
- coef_ready  out  1  loader idle; a transfer occurs when valid and ready are both high at a clock edge.
- coef  in  W  unsigned coefficient A.
- rd_sel  in  9  one-hot word select; bit i selects entry i; bit 8 selects the 2A entry.
- rd_data  out  W+4  registered read data.
- lut_valid  out  1  table holds a complete, consistent coefficient set.
- busy  out  1  load in progress.
- load_done  out  1  one-cycle pulse when the last entry is written.

## Operation
- Entries 0..7 hold (2i+1)·A. Entry 8 holds 2A.
- Maximum value is 15·63 = 945, which is below 1024, so W+4 bits never overflow. The adder is W+4 bits wide with no saturation.
- FSM states:
  - IDLE: coef_ready=1. On a transfer, capture A, set acc=A, idx=0, lut_valid←0, and go to LOAD_ODD.
  - LOAD_ODD: each cycle write entry[idx]←acc, then acc←acc+2A and idx←idx+1. After idx=7 is written, go to LOAD_2A.
  - LOAD_2A: write entry[8]←2A (A shifted left by 1), lut_valid←1, load_done←1, go to IDLE.
- busy=1 in LOAD_ODD and LOAD_2A. coef_ready = ~busy, so coef_valid while busy is ignored and no new coefficient is captured.
- Read path:
  - rd_data is registered.
  - If rd_sel[8]=1, return entry 8 regardless of other bits. This makes the decoder's 9'b100000001 return 2A.
  - Otherwise return the entry at the lowest set bit of rd_sel.
  - If rd_sel=0, return 0.
  - If lut_valid=0, return 0 irrespective of rd_sel.
- Reload from IDLE with lut_valid=1: lut_valid drops at the acceptance edge. Old entries remain in storage but reads return 0 until the new load completes.
- Reset:
  - All outputs go to 0, except coef_ready, which is 1.
  - All nine entries go to 0, acc=0, idx=0, and the state returns to IDLE.
  - Reset mid-load aborts the load, and lut_valid stays 0.
- coef=0 is legal. It produces an all-zero table with lut_valid=1.

## Timing
- Acceptance edge is T. Entry i (0..7) is written at edge T+1+i, and entry 8 at edge T+9.
- lut_valid and load_done are high after edge T+9. load_done drops after edge T+10.
- coef_ready is low from after edge T until after edge T+9. The earliest next acceptance is edge T+10.
- Load latency is 9 cycles after acceptance, and throughput is one coefficient per 10 cycles.
- Read latency is 1 cycle: rd_sel sampled at edge N appears on rd_data after edge N.
- A read of entry k at the same edge it is written returns the old value, and lut_valid gates that read anyway.
- Reset has priority over every other event at the same edge, including a handshake.

## Structure
- Shared package holds:
  - constant LUT_DEPTH=9 and IDX_2A=8;
  - the FSM state enum (IDLE, LOAD_ODD, LOAD_2A);
  - the LUT word width function W+4.
- One sub-module, lut_regfile: 9×(W+4) register storage with a single write port (we, widx, wdata), synchronous clear, and the registered one-hot priority read described above.
- The top level contains the FSM, accumulator, index counter and handshake.

## Test plan
- Reset, then coef=32 accepted → after edge T+9 entries are 32,96,160,224,288,352,416,480,64, lut_valid=1, and load_done is high for exactly one cycle. rd_sel=9'b000000100 gives rd_data=160 one cycle later.
- coef=63 → entry 7=945, entry 8=126, rd_sel=9'b100000001 → 126, with no wrap.
- coef_valid held high with coef=5 during a coef=32 load → coef_ready=0 for 9 cycles and the table ends at 32-multiples. The coef=5 transfer is then accepted at T+10.
- Assert reset at T+4 of a coef=32 load → next cycle lut_valid=0, busy=0, coef_ready=1, and every rd_sel gives 0. A subsequent load of coef=7 completes normally (entry 7=105).
- coef=0 → all entries 0 and lut_valid=1. Then rd_sel=0 with lut_valid=1 → rd_data=0.
- Reload coef=10 over a valid coef=32 table → lut_valid drops at acceptance and reads return 0 during the load. Afterwards entry 3=70.
